// File: rtl/multicycle_alu.sv
// multicycle_alu: WIDTH-bit ALU behind a valid/ready handshake with iterative shifts/rotates.
// Define MULTICYCLE_ALU_MULDIV_EN to build the iterative unsigned multiply/divide datapath.
module multicycle_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             overflow,
  output logic             less,
  output logic             equal,
  output logic             greater,
  output logic             zero
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_NOT  = 5'b00101;
  localparam logic [4:0] OP_CMPS = 5'b00110;
  localparam logic [4:0] OP_CMPU = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_LSR  = 5'b01001;
  localparam logic [4:0] OP_ASR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
`ifdef MULTICYCLE_ALU_MULDIV_EN
  localparam logic [4:0] OP_MULU = 5'b01100;
  localparam logic [4:0] OP_DIVU = 5'b01101;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT          state;
  logic [4:0]     opReg;
  logic [SHW-1:0] cnt;

  // One bit position per call; the MSB of the result is the bit moved out.
  function automatic logic [WIDTH:0] shiftStep(input logic [4:0] o, input logic [WIDTH-1:0] v);
    logic [WIDTH:0] res;
    case (o)
      OP_SHL:  res = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
      OP_LSR:  res = {v[0], 1'b0, v[WIDTH-1:1]};
      OP_ASR:  res = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      default: res = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
    endcase
    return res;
  endfunction

  logic [SHW-1:0] shAmt;
  logic [4:0]     curOp;
  logic [WIDTH-1:0] shIn;
  logic [WIDTH:0]   shOut;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             signedOv;
  logic [WIDTH-1:0] sQ;
  logic             sOv, sLt, sEq, sGt;

  assign shAmt    = B[SHW-1:0];
  // The first iteration runs on the accept edge straight from the operand bus.
  assign curOp    = (state == IDLE) ? op : opReg;
  assign shIn     = (state == IDLE) ? A : Q;
  assign shOut    = shiftStep(curOp, shIn);
  assign sum      = {1'b0, A} + {1'b0, B};
  assign diff     = {1'b0, A} - {1'b0, B};
  assign signedOv = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);

  always_comb begin
    sQ  = '0;
    sOv = 1'b0;
    sLt = 1'b0;
    sEq = 1'b0;
    sGt = 1'b0;
    case (op)
      OP_ADD: begin sQ = sum[WIDTH-1:0];  sOv = sum[WIDTH];  end
      OP_SUB: begin sQ = diff[WIDTH-1:0]; sOv = diff[WIDTH]; end
      OP_AND: sQ = A & B;
      OP_OR:  sQ = A | B;
      OP_XOR: sQ = A ^ B;
      OP_NOT: sQ = ~B;
      OP_CMPS: begin
        sQ  = diff[WIDTH-1:0];
        sLt = diff[WIDTH-1] ^ signedOv;
        sEq = (A == B);
        sGt = !sLt && !sEq;
      end
      OP_CMPU: begin
        sQ  = diff[WIDTH-1:0];
        sLt = diff[WIDTH];
        sEq = (A == B);
        sGt = !sLt && !sEq;
      end
      default: ;
    endcase
  end

`ifdef MULTICYCLE_ALU_MULDIV_EN
  // Shift-add: partial product high half in hi, multiplier bits consumed from lo.
  function automatic logic [2*WIDTH-1:0] mulStep(input logic [WIDTH-1:0] hi,
                                                 input logic [WIDTH-1:0] lo,
                                                 input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    return {s[WIDTH:1], s[0], lo[WIDTH-1:1]};
  endfunction

  // Restoring step: {remainder, quotient}; a zero divisor yields all-ones and R = A.
  function automatic logic [2*WIDTH-1:0] divStep(input logic [WIDTH-1:0] rem,
                                                 input logic [WIDTH-1:0] quo,
                                                 input logic [WIDTH-1:0] d);
    logic [WIDTH:0] t;
    logic [WIDTH:0] td;
    t  = {rem, quo[WIDTH-1]};
    td = t - {1'b0, d};
    if (t >= {1'b0, d}) return {td[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
    else                return {t[WIDTH-1:0],  quo[WIDTH-2:0], 1'b0};
  endfunction

  logic [WIDTH-1:0]   bReg;
  logic [WIDTH-1:0]   hiIn;
  logic [WIDTH-1:0]   dIn;
  logic [2*WIDTH-1:0] mulOut;
  logic [2*WIDTH-1:0] divOut;

  assign hiIn   = (state == IDLE) ? '0 : R;
  assign dIn    = (state == IDLE) ? B : bReg;
  assign mulOut = mulStep(hiIn, shIn, dIn);
  assign divOut = divStep(hiIn, shIn, dIn);
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      opReg    <= '0;
      cnt      <= '0;
      Q        <= '0;
      R        <= '0;
      overflow <= 1'b0;
      less     <= 1'b0;
      equal    <= 1'b0;
      greater  <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          opReg   <= op;
          less    <= 1'b0;
          equal   <= 1'b0;
          greater <= 1'b0;
          R       <= '0;
          state   <= DONE;
          case (op)
            OP_SHL, OP_LSR, OP_ASR, OP_ROL: begin
              if (shAmt == '0) begin
                Q        <= A;
                overflow <= 1'b0;
                zero     <= (A == '0);
              end else begin
                Q        <= shOut[WIDTH-1:0];
                overflow <= shOut[WIDTH];
                zero     <= (shOut[WIDTH-1:0] == '0);
                cnt      <= shAmt - 1'b1;
                if (shAmt != SHW'(1)) state <= RUN;
              end
            end
`ifdef MULTICYCLE_ALU_MULDIV_EN
            OP_MULU: begin
              bReg     <= B;
              {R, Q}   <= mulOut;
              overflow <= |mulOut[2*WIDTH-1:WIDTH];
              zero     <= (mulOut[WIDTH-1:0] == '0);
              cnt      <= SHW'(WIDTH - 1);
              state    <= RUN;
            end
            OP_DIVU: begin
              bReg     <= B;
              {R, Q}   <= divOut;
              overflow <= (B == '0);
              zero     <= (divOut[WIDTH-1:0] == '0);
              cnt      <= SHW'(WIDTH - 1);
              state    <= RUN;
            end
`endif
            default: begin
              Q        <= sQ;
              overflow <= sOv;
              less     <= sLt;
              equal    <= sEq;
              greater  <= sGt;
              zero     <= (sQ == '0);
            end
          endcase
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == SHW'(1)) state <= DONE;
`ifdef MULTICYCLE_ALU_MULDIV_EN
          if (opReg == OP_MULU) begin
            {R, Q}   <= mulOut;
            overflow <= |mulOut[2*WIDTH-1:WIDTH];
            zero     <= (mulOut[WIDTH-1:0] == '0);
          end else if (opReg == OP_DIVU) begin
            {R, Q}   <= divOut;
            zero     <= (divOut[WIDTH-1:0] == '0);
          end else begin
`else
          begin
`endif
            Q        <= shOut[WIDTH-1:0];
            overflow <= shOut[WIDTH];
            zero     <= (shOut[WIDTH-1:0] == '0);
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=16): vector table, scoreboard queue, handshake corners.
module tb_multicycle_alu;
  localparam int W = 16;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_NOT  = 5'b00101;
  localparam logic [4:0] OP_CMPS = 5'b00110;
  localparam logic [4:0] OP_CMPU = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_LSR  = 5'b01001;
  localparam logic [4:0] OP_ASR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MULU = 5'b01100;
  localparam logic [4:0] OP_DIVU = 5'b01101;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] A, B, Q, R;
  logic [4:0]   op;
  logic         overflow, less, equal, greater, zero;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .Q(Q), .R(R), .overflow(overflow), .less(less), .equal(equal),
    .greater(greater), .zero(zero)
  );

  always #5 clk = ~clk;

  // flags packed as {overflow, less, equal, greater, zero}
  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [4:0]   flags;
    int           lat;
    logic         chkOv;
  } vecT;

  int  checks = 0;
  int  failures = 0;
  vecT vecs[$];
  vecT sb[$];

  function automatic vecT mk(input logic [4:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] q, input logic [W-1:0] r, input logic [4:0] fl,
                             input int lat, input logic chkOv);
    vecT v;
    v.op = o; v.a = a; v.b = b; v.q = q; v.r = r; v.flags = fl; v.lat = lat; v.chkOv = chkOv;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic runVec(input vecT v);
    vecT  e;
    int   lat;
    logic busyLeak;
    logic [4:0] actFl;
    @(negedge clk);
    check("idle in_ready", {63'd0, in_ready}, 64'd1);
    A = v.a; B = v.b; op = v.op; in_valid = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    busyLeak = 1'b0;
    while (!out_valid && lat < 100) begin
      busyLeak |= in_ready;
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    if (!out_valid) begin
      checks++;
      failures++;
      $display("FAIL timeout op=%b a=%h b=%h: out_valid never rose", e.op, e.a, e.b);
      return;
    end
    actFl = {e.chkOv ? overflow : e.flags[4], less, equal, greater, zero};
    check($sformatf("result op=%b a=%h b=%h {Q,R,flags}", e.op, e.a, e.b),
          {27'd0, Q, R, actFl}, {27'd0, e.q, e.r, e.flags});
    check($sformatf("latency op=%b b=%h", e.op, e.b), 64'(lat), 64'(e.lat));
    check($sformatf("busy in_ready op=%b", e.op), {62'd0, busyLeak, in_ready}, 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("handoff {out_valid,in_ready}", {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; op = '0;

    vecs.push_back(mk(OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 5'b10001, 1, 1'b1));
    vecs.push_back(mk(OP_ADD,  16'h1234, 16'h1111, 16'h2345, 16'h0000, 5'b00000, 1, 1'b1));
    vecs.push_back(mk(OP_SUB,  16'h0005, 16'h0007, 16'hFFFE, 16'h0000, 5'b10000, 1, 1'b1));
    vecs.push_back(mk(OP_SUB,  16'h0007, 16'h0005, 16'h0002, 16'h0000, 5'b00000, 1, 1'b1));
    vecs.push_back(mk(OP_AND,  16'hF0F0, 16'hFF00, 16'hF000, 16'h0000, 5'b00000, 1, 1'b1));
    vecs.push_back(mk(OP_OR,   16'hF0F0, 16'h0F0F, 16'hFFFF, 16'h0000, 5'b00000, 1, 1'b1));
    vecs.push_back(mk(OP_XOR,  16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 5'b00001, 1, 1'b1));
    vecs.push_back(mk(OP_NOT,  16'h1234, 16'h00FF, 16'hFF00, 16'h0000, 5'b00000, 1, 1'b1));
    vecs.push_back(mk(OP_CMPS, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 5'b01000, 1, 1'b0));
    vecs.push_back(mk(OP_CMPU, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 5'b00010, 1, 1'b0));
    vecs.push_back(mk(OP_CMPS, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 5'b00101, 1, 1'b0));
    vecs.push_back(mk(OP_CMPS, 16'h0003, 16'hFFFF, 16'h0004, 16'h0000, 5'b00010, 1, 1'b0));
    vecs.push_back(mk(OP_CMPU, 16'h0003, 16'hFFFF, 16'h0004, 16'h0000, 5'b01000, 1, 1'b0));
    vecs.push_back(mk(OP_SHL,  16'h8001, 16'h0001, 16'h0002, 16'h0000, 5'b10000, 1, 1'b1));
    vecs.push_back(mk(OP_SHL,  16'h0F00, 16'h0004, 16'hF000, 16'h0000, 5'b00000, 4, 1'b1));
    vecs.push_back(mk(OP_LSR,  16'h0003, 16'h0002, 16'h0000, 16'h0000, 5'b10001, 2, 1'b1));
    vecs.push_back(mk(OP_ASR,  16'h8000, 16'h0003, 16'hF000, 16'h0000, 5'b00000, 3, 1'b1));
    vecs.push_back(mk(OP_ASR,  16'h1234, 16'h0010, 16'h1234, 16'h0000, 5'b00000, 1, 1'b1));
    vecs.push_back(mk(OP_ROL,  16'h8001, 16'h0004, 16'h0018, 16'h0000, 5'b00000, 4, 1'b1));
    vecs.push_back(mk(OP_SHL,  16'h0003, 16'h000F, 16'h8000, 16'h0000, 5'b10000, 15, 1'b1));
    vecs.push_back(mk(5'b01110, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 5'b00001, 1, 1'b1));
    vecs.push_back(mk(5'b11111, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 5'b00001, 1, 1'b1));
`ifdef MULTICYCLE_ALU_MULDIV_EN
    vecs.push_back(mk(OP_MULU, 16'h0100, 16'h0101, 16'h0100, 16'h0001, 5'b10000, 16, 1'b1));
    vecs.push_back(mk(OP_MULU, 16'h0003, 16'h0003, 16'h0009, 16'h0000, 5'b00000, 16, 1'b1));
    vecs.push_back(mk(OP_DIVU, 16'h0007, 16'h0002, 16'h0003, 16'h0001, 5'b00000, 16, 1'b1));
    vecs.push_back(mk(OP_DIVU, 16'h0007, 16'h0000, 16'hFFFF, 16'h0007, 5'b10000, 16, 1'b1));
    vecs.push_back(mk(OP_DIVU, 16'hFFFF, 16'h00FF, 16'h0101, 16'h0000, 5'b00000, 16, 1'b1));
`else
    vecs.push_back(mk(OP_MULU, 16'h0003, 16'h0003, 16'h0000, 16'h0000, 5'b00001, 1, 1'b1));
    vecs.push_back(mk(OP_DIVU, 16'h0007, 16'h0000, 16'h0000, 16'h0000, 5'b00001, 1, 1'b1));
`endif

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset {in_ready,out_valid}", {62'd0, in_ready, out_valid}, 64'd2);
    check("reset {Q,R,flags}", {27'd0, Q, R, overflow, less, equal, greater, zero}, 64'd0);
    reset = 1'b0;

    foreach (vecs[i]) runVec(vecs[i]);

    // result held while the consumer stalls; new requests ignored meanwhile
    @(negedge clk);
    A = 16'h8001; B = 16'h0004; op = OP_ROL; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    check("hold: out_valid reached", {63'd0, out_valid}, 64'd1);
    A = 16'h0001; B = 16'h0001; op = OP_ADD; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("hold cycle %0d {Q,R,flags}", k),
            {27'd0, Q, R, overflow, less, equal, greater, zero},
            {27'd0, 16'h0018, 16'h0000, 5'b00000});
      check($sformatf("hold cycle %0d {out_valid,in_ready}", k),
            {62'd0, out_valid, in_ready}, 64'd2);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold release {out_valid,in_ready}", {62'd0, out_valid, in_ready}, 64'd1);

    // reset while an iterative shift is in flight
    A = 16'h0001; B = 16'h0008; op = OP_SHL; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid-run {out_valid,in_ready}", {62'd0, out_valid, in_ready}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset mid-run {out_valid,in_ready}", {62'd0, out_valid, in_ready}, 64'd1);
    check("reset mid-run {Q,R,flags}", {27'd0, Q, R, overflow, less, equal, greater, zero}, 64'd0);
    runVec(vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
